segway_seq: RTL and testbench

//  Power/steer sequencer feeding segway_math's control inputs (pwr_up, ss_tmr, en_steer).

---
 rtl/segway_seq_if.sv | 29 ++
 rtl/segway_seq.sv | 185 ++++++++++++++++++
 tb/tb_segway_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/segway_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : segway_seq_if
// Purpose  : Control bundle between the load-cell front end, segway_seq and
//            segway_math.
// Revision : 1.0
// ============================================================================
interface segway_seq_if;
    logic        pwr_req;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        too_fast;
    logic        pwr_up;
    logic [7:0]  ss_tmr;
    logic        en_steer;
    logic        rider_off;
    logic        fault;

    modport master (
        output pwr_req, lft_ld, rght_ld, too_fast,
        input  pwr_up, ss_tmr, en_steer, rider_off, fault
    );

    modport slave (
        input  pwr_req, lft_ld, rght_ld, too_fast,
        output pwr_up, ss_tmr, en_steer, rider_off, fault
    );
endinterface
`default_nettype wire

// File: rtl/segway_seq.sv
`default_nettype none
// ============================================================================
// Module   : segway_seq
// Purpose  : Power/steer sequencer: soft-start ramp, rider/balance gated
//            steering enable and sustained-overspeed ramp-down.
// Revision : 1.0
// ============================================================================
module segway_seq #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          SS_DIV       = 8,
    parameter int          STABLE_W     = 26,
    parameter int          TF_CYC       = 16
) (
    input  logic         clk,
    input  logic         rst,
    segway_seq_if.slave  bus
);

    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_RAMP_UP  = 3'd1;
    localparam logic [2:0] S_BALANCE  = 3'd2;
    localparam logic [2:0] S_STEER    = 3'd3;
    localparam logic [2:0] S_RAMP_DN  = 3'd4;

    localparam logic [SS_DIV-1:0]   c_presc_one  = {{(SS_DIV-1){1'b0}}, 1'b1};
    localparam logic [STABLE_W-1:0] c_stab_one   = {{(STABLE_W-1){1'b0}}, 1'b1};
    localparam logic [STABLE_W-1:0] c_stab_last  = {{(STABLE_W-1){1'b1}}, 1'b0};
    localparam logic [7:0]          c_tf_last    = 8'(TF_CYC - 1);
    localparam logic [12:0]         c_present_th = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0]         c_gone_th    = {1'b0, MIN_RIDER_WT - WT_HYST};

    logic [2:0]          r_state;
    logic [SS_DIV-1:0]   r_presc;
    logic [STABLE_W-1:0] r_stab_cnt;
    logic [7:0]          r_tf_cnt;
    logic [7:0]          r_ss_tmr;
    logic                r_pwr_up;
    logic                r_en_steer;
    logic                r_rider_off;
    logic                r_fault;

    logic [12:0]         w_sum;
    logic [12:0]         w_diff;
    logic                w_present;
    logic                w_gone;
    logic                w_level;
    logic                w_tilted;
    logic                w_tick;
    logic                w_tf_trip;
    logic [7:0]          w_tf_inc;

    logic [2:0]          w_state_nxt;
    logic [SS_DIV-1:0]   w_presc_nxt;
    logic [STABLE_W-1:0] w_stab_nxt;
    logic [7:0]          w_tf_nxt;
    logic [7:0]          w_ss_nxt;
    logic                w_rider_off_nxt;
    logic                w_fault_nxt;

    // Weight and balance qualifiers, all compared as 13-bit unsigned.
    assign w_sum     = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    assign w_diff    = {1'b0, (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                                           : (bus.rght_ld - bus.lft_ld)};
    assign w_present = (w_sum > c_present_th);
    assign w_gone    = (w_sum < c_gone_th);
    assign w_level   = (w_diff < (w_sum >> 2));
    assign w_tilted  = (w_diff > (w_sum >> 1));

    assign w_tick    = &r_presc;
    assign w_tf_inc  = bus.too_fast ? (r_tf_cnt + 8'd1) : 8'd0;
    assign w_tf_trip = bus.too_fast && (r_tf_cnt == c_tf_last);

    always_comb begin
        w_state_nxt     = r_state;
        w_ss_nxt        = r_ss_tmr;
        w_fault_nxt     = r_fault;
        w_rider_off_nxt = 1'b0;
        w_stab_nxt      = '0;
        w_tf_nxt        = '0;

        case (r_state)
            S_OFF: begin
                w_ss_nxt = 8'h00;
                if (bus.pwr_req) begin
                    w_state_nxt = S_RAMP_UP;
                    w_fault_nxt = 1'b0;
                end
            end

            S_RAMP_UP: begin
                if (!bus.pwr_req) begin
                    w_state_nxt = S_RAMP_DN;
                end else if (w_tick) begin
                    if (r_ss_tmr == 8'hFF) begin
                        w_state_nxt = S_BALANCE;
                    end else begin
                        w_ss_nxt = r_ss_tmr + 8'd1;
                    end
                end
            end

            // Ramp-down is never aborted; a renewed request waits for OFF.
            S_RAMP_DN: begin
                if (w_tick) begin
                    if (r_ss_tmr == 8'h00) begin
                        w_state_nxt = S_OFF;
                    end else begin
                        w_ss_nxt = r_ss_tmr - 8'd1;
                    end
                end
            end

            S_BALANCE, S_STEER: begin
                w_ss_nxt = 8'hFF;
                w_tf_nxt = w_tf_inc;
                if (w_tf_trip || !bus.pwr_req) begin
                    w_state_nxt = S_RAMP_DN;
                    w_tf_nxt    = '0;
                    if (w_tf_trip) begin
                        w_fault_nxt = 1'b1;
                    end
                end else if (r_state == S_STEER) begin
                    if (w_gone) begin
                        w_state_nxt     = S_BALANCE;
                        w_rider_off_nxt = 1'b1;
                    end else if (w_tilted) begin
                        w_state_nxt = S_BALANCE;
                    end
                end else if (w_present && w_level) begin
                    if (r_stab_cnt == c_stab_last) begin
                        w_state_nxt = S_STEER;
                    end else begin
                        w_stab_nxt = r_stab_cnt + c_stab_one;
                    end
                end
            end

            default: begin
                w_state_nxt = S_OFF;
                w_ss_nxt    = 8'h00;
            end
        endcase
    end

    // Prescaler restarts on every state change so each ramp step is a full period.
    always_comb begin
        w_presc_nxt = '0;
        if ((w_state_nxt == r_state) && ((r_state == S_RAMP_UP) || (r_state == S_RAMP_DN))) begin
            w_presc_nxt = r_presc + c_presc_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_presc     <= '0;
            r_stab_cnt  <= '0;
            r_tf_cnt    <= '0;
            r_ss_tmr    <= 8'h00;
            r_pwr_up    <= 1'b0;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_stab_cnt  <= w_stab_nxt;
            r_tf_cnt    <= w_tf_nxt;
            r_ss_tmr    <= w_ss_nxt;
            r_pwr_up    <= (w_state_nxt != S_OFF);
            r_en_steer  <= (w_state_nxt == S_STEER);
            r_rider_off <= w_rider_off_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign bus.pwr_up    = r_pwr_up;
    assign bus.ss_tmr    = r_ss_tmr;
    assign bus.en_steer  = r_en_steer;
    assign bus.rider_off = r_rider_off;
    assign bus.fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_segway_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_segway_seq
// Purpose  : Directed plus randomized check of segway_seq against a
//            phase/elapsed-time reference model.
// Revision : 1.0
// ============================================================================
module tb_segway_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    segway_seq_if bus ();

    segway_seq #(
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040),
        .SS_DIV       (2),
        .STABLE_W     (4),
        .TF_CYC       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: current phase, edges spent in it, and ramp start level.
    typedef enum int {P_OFF, P_UP, P_BAL, P_STEER, P_DN} phase_t;
    phase_t m_phase;
    int     m_t;
    int     m_base;
    int     m_run;
    int     m_tf;
    bit     m_fault;
    bit     m_pulse;

    function automatic void model_reset();
        m_phase = P_OFF;
        m_t     = 0;
        m_base  = 0;
        m_run   = 0;
        m_tf    = 0;
        m_fault = 1'b0;
        m_pulse = 1'b0;
    endfunction

    function automatic int exp_ss();
        case (m_phase)
            P_OFF:   return 0;
            P_UP:    return m_base + m_t / 4;
            P_DN:    return m_base - m_t / 4;
            default: return 255;
        endcase
    endfunction

    function automatic void enter(phase_t p, int base);
        m_phase = p;
        m_base  = base;
        m_t     = 0;
        m_run   = 0;
    endfunction

    function automatic void model_edge(bit pr, logic [11:0] l, logic [11:0] r, bit tf);
        int sum, diff, ss;
        bit present, gone, level, tilted, tick;
        sum     = int'(l) + int'(r);
        diff    = (l > r) ? int'(l) - int'(r) : int'(r) - int'(l);
        present = sum > 512;
        gone    = sum < 448;
        level   = diff < sum / 4;
        tilted  = diff > sum / 2;
        ss      = exp_ss();
        tick    = (m_t % 4) == 3;
        m_pulse = 1'b0;
        case (m_phase)
            P_OFF: if (pr) begin m_fault = 1'b0; enter(P_UP, 0); end
            P_UP: begin
                if (!pr) enter(P_DN, ss);
                else if (tick && ss == 255) enter(P_BAL, 255);
                else m_t++;
            end
            P_DN: begin
                if (tick && ss == 0) enter(P_OFF, 0);
                else m_t++;
            end
            default: begin
                m_tf = tf ? m_tf + 1 : 0;
                if (m_tf >= 4) begin
                    m_fault = 1'b1;
                    enter(P_DN, 255);
                end else if (!pr) begin
                    enter(P_DN, 255);
                end else if (m_phase == P_STEER) begin
                    if (gone) begin m_pulse = 1'b1; enter(P_BAL, 255); end
                    else if (tilted) enter(P_BAL, 255);
                end else begin
                    m_run = (present && level) ? m_run + 1 : 0;
                    if (m_run == 15) enter(P_STEER, 255);
                end
            end
        endcase
        if (m_phase inside {P_OFF, P_UP, P_DN}) m_tf = 0;
    endfunction

    task automatic expect_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        expect_eq({tag, ".pwr_up"},    {7'd0, bus.pwr_up},    {7'd0, m_phase != P_OFF});
        expect_eq({tag, ".ss_tmr"},    bus.ss_tmr,            8'(exp_ss()));
        expect_eq({tag, ".en_steer"},  {7'd0, bus.en_steer},  {7'd0, m_phase == P_STEER});
        expect_eq({tag, ".rider_off"}, {7'd0, bus.rider_off}, {7'd0, m_pulse});
        expect_eq({tag, ".fault"},     {7'd0, bus.fault},     {7'd0, m_fault});
    endtask

    task automatic step(input bit pr, input logic [11:0] l, input logic [11:0] r,
                        input bit tf, input string tag);
        @(negedge clk);
        bus.pwr_req  = pr;
        bus.lft_ld   = l;
        bus.rght_ld  = r;
        bus.too_fast = tf;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(pr, l, r, tf);
        #1;
        check(tag);
    endtask

    initial begin
        bit          pr;
        int          mode;
        logic [11:0] l;
        logic [11:0] r;
        bit          tf;

        rst          = 1'b1;
        bus.pwr_req  = 1'b0;
        bus.lft_ld   = '0;
        bus.rght_ld  = '0;
        bus.too_fast = 1'b0;
        model_reset();

        step(0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, "reset");
        expect_eq("reset_pwr_up", {7'd0, bus.pwr_up}, 8'h00);
        expect_eq("reset_ss_tmr", bus.ss_tmr, 8'h00);
        rst = 1'b0;

        // Reset in the middle of a ramp.
        step(1, 0, 0, 0, "off_to_up");
        repeat (256) step(1, 0, 0, 0, "ramp_up_40");
        expect_eq("ramp_at_40", bus.ss_tmr, 8'h40);
        rst = 1'b1;
        step(1, 0, 0, 0, "rst_mid_ramp");
        expect_eq("rst_mid_ss_tmr", bus.ss_tmr, 8'h00);
        expect_eq("rst_mid_pwr_up", {7'd0, bus.pwr_up}, 8'h00);
        step(1, 0, 0, 0, "rst_mid_ramp");
        rst = 1'b0;

        // Full soft-start ramp with no rider.
        step(1, 0, 0, 0, "off_to_up");
        repeat (1020) step(1, 0, 0, 0, "ramp_up_full");
        expect_eq("ramp_full_ss", bus.ss_tmr, 8'hFF);
        expect_eq("ramp_full_en", {7'd0, bus.en_steer}, 8'h00);
        repeat (4) step(1, 0, 0, 0, "to_balance");

        // Stability count with a tilted interruption.
        repeat (7) step(1, 12'h180, 12'h180, 0, "bal_count");
        step(1, 12'h300, 12'h000, 0, "bal_tilt");
        repeat (14) step(1, 12'h180, 12'h180, 0, "bal_count2");
        expect_eq("bal_14_no_en", {7'd0, bus.en_steer}, 8'h00);
        step(1, 12'h180, 12'h180, 0, "bal_count2");
        expect_eq("bal_15_en", {7'd0, bus.en_steer}, 8'h01);

        // Rider-off hysteresis boundary.
        repeat (3) step(1, 12'h0E0, 12'h0E0, 0, "steer_edge");
        expect_eq("steer_at_1c0", {7'd0, bus.en_steer}, 8'h01);
        step(1, 12'h0D0, 12'h0D0, 0, "steer_gone");
        expect_eq("gone_pulse", {7'd0, bus.rider_off}, 8'h01);
        expect_eq("gone_en", {7'd0, bus.en_steer}, 8'h00);
        step(1, 12'h0D0, 12'h0D0, 0, "after_gone");
        expect_eq("pulse_one_cycle", {7'd0, bus.rider_off}, 8'h00);

        // Overspeed: short burst ignored, sustained burst trips.
        repeat (15) step(1, 12'h180, 12'h180, 0, "re_steer");
        repeat (3) step(1, 12'h180, 12'h180, 1, "tf_short");
        step(1, 12'h180, 12'h180, 0, "tf_short_end");
        expect_eq("tf3_no_fault", {7'd0, bus.fault}, 8'h00);
        expect_eq("tf3_still_en", {7'd0, bus.en_steer}, 8'h01);
        repeat (4) step(1, 12'h180, 12'h180, 1, "tf_trip");
        expect_eq("tf4_fault", {7'd0, bus.fault}, 8'h01);
        expect_eq("tf4_en_off", {7'd0, bus.en_steer}, 8'h00);
        repeat (508) step(0, 12'h180, 12'h180, 0, "ramp_dn");
        expect_eq("ramp_dn_80", bus.ss_tmr, 8'h80);

        // Renewed request does not abort the ramp-down.
        repeat (512) step(1, 12'h180, 12'h180, 0, "ramp_dn_req");
        expect_eq("ramp_dn_zero", bus.ss_tmr, 8'h00);
        expect_eq("ramp_dn_zero_pwr", {7'd0, bus.pwr_up}, 8'h01);
        repeat (4) step(1, 12'h180, 12'h180, 0, "to_off");
        expect_eq("off_pwr_up", {7'd0, bus.pwr_up}, 8'h00);
        expect_eq("off_fault_held", {7'd0, bus.fault}, 8'h01);
        step(1, 12'h180, 12'h180, 0, "restart");
        expect_eq("restart_fault_clr", {7'd0, bus.fault}, 8'h00);
        expect_eq("restart_pwr_up", {7'd0, bus.pwr_up}, 8'h01);

        // Randomized traffic in load/overspeed regimes.
        pr   = 1'b1;
        mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 16 == 0) mode = int'($urandom_range(0, 9));
            if ($urandom_range(0, 699) == 0) pr = ~pr;
            case (mode)
                5: begin
                    l = 12'($urandom_range(12'h0C0, 12'h120));
                    r = 12'($urandom_range(12'h0C0, 12'h120));
                end
                6: begin
                    l = 12'($urandom_range(12'h200, 12'h400));
                    r = 12'($urandom_range(0, 12'h060));
                end
                7, 8, 9: begin
                    l = 12'($urandom);
                    r = 12'($urandom);
                end
                default: begin
                    l = 12'($urandom_range(12'h110, 12'h200));
                    r = 12'(int'(l) + int'($urandom_range(0, 12'h040)) - 12'h020);
                end
            endcase
            tf  = (mode == 8) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 2999) == 0);
            step(pr, l, r, tf, "random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
